// File: rtl/parity_check_shifter_if.sv
// -----------------------------------------------------------------------------
// parity_check_shifter_if
//   Groups the two handshaked sides of the parity check shifter. The word
//   input (in_*) and the serial output (ser_*) each have a valid/ready pair.
//
//   Signals
//     in_valid   : upstream presents in_word / in_control
//     in_ready   : block can take a word this cycle
//     in_word    : encoded word {d6,d5,d4,p,d3,d2,d1,d0}
//     in_control : encoding mode the word was produced with
//     ser_valid  : ser_data carries a frame bit
//     ser_ready  : downstream takes ser_data this cycle
//     ser_data   : current serial bit
//     ser_first  : first bit of a frame, qualified by ser_valid
//
//   Modports
//     slave  : the parity check shifter itself
//     master : the environment (encoder upstream plus serial link downstream)
// -----------------------------------------------------------------------------
interface parity_check_shifter_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_word;
  logic       in_control;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_data;
  logic       ser_first;

  modport slave (
    input  in_valid,
    input  in_word,
    input  in_control,
    input  ser_ready,
    output in_ready,
    output ser_valid,
    output ser_data,
    output ser_first
  );

  modport master (
    output in_valid,
    output in_word,
    output in_control,
    output ser_ready,
    input  in_ready,
    input  ser_valid,
    input  ser_data,
    input  ser_first
  );
endinterface

// File: rtl/parity_check_shifter.sv
// -----------------------------------------------------------------------------
// parity_check_shifter
//   Downstream consumer of the majority-bit encoder. Takes 8-bit encoded words,
//   recomputes the check bit at position 4, tracks mismatch and word
//   statistics, and serialises the 7 recovered data bits with backpressure.
//
//   Parameters
//     CNT_W     : width of err_count / word_count
//     MSB_FIRST : 1 = emit d6 first, 0 = emit d0 first
//
//   Ports
//     clk        : system clock, rising edge
//     rst_n      : asynchronous active-low reset
//     bus        : handshake interface (slave side), see parity_check_shifter_if
//     clr_cnt    : synchronous clear of both counters
//     err_flag   : check-bit mismatch of the last accepted word
//     err_count  : saturating count of mismatched words
//     word_count : wrapping count of accepted words
// -----------------------------------------------------------------------------
module parity_check_shifter #(
  parameter int CNT_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  parity_check_shifter_if.slave  bus,
  input  logic                   clr_cnt,
  output logic                   err_flag,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       word_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'd6;

  // Majority vote over d5..d0 (d6 is not covered by the check bit).
  // Mode 0 flags a zero majority, mode 1 a one majority; a 3/3 tie gives 0.
  function automatic logic expected_check(input logic [5:0] bits, input logic mode);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < 6; i++) begin
      ones = ones + {2'b00, bits[i]};
    end
    if (mode) begin
      expected_check = (ones > 3'd3);
    end else begin
      expected_check = (ones < 3'd3);
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    wrap_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_q,      state_d;
  logic [2:0]       idx_q,        idx_d;
  logic [6:0]       data_q,       data_d;
  logic             err_flag_q,   err_flag_d;
  logic [CNT_W-1:0] err_count_q,  err_count_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  logic       accept;
  logic       transfer;
  logic       mismatch;
  logic [6:0] in_data;
  logic [7:0] emit_order;

  assign in_data  = {bus.in_word[7:5], bus.in_word[3:0]};
  assign mismatch = bus.in_word[4] !=
                    expected_check({bus.in_word[6:5], bus.in_word[3:0]}, bus.in_control);

  // in_ready opens on the last transfer of a frame so the next word follows
  // without a bubble; it depends only on state, index and ser_ready.
  assign bus.in_ready = (state_q == IDLE) ||
                        ((state_q == SHIFT) && (idx_q == LAST_IDX) && bus.ser_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign transfer     = (state_q == SHIFT) && bus.ser_ready;

  // Bits rearranged so that emit_order[idx] is the idx-th bit on the wire.
  // Padded to 8 entries so every 3-bit index value is in range.
  always_comb begin
    emit_order = 8'h00;
    for (int i = 0; i < 7; i++) begin
      if (MSB_FIRST) begin
        emit_order[i] = data_q[6-i];
      end else begin
        emit_order[i] = data_q[i];
      end
    end
  end

  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.ser_data  = emit_order[idx_q];
  assign bus.ser_first = (state_q == SHIFT) && (idx_q == 3'd0);

  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;
  assign word_count = word_count_q;

  // Frame sequencing: next state, index and data register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          idx_d   = 3'd0;
          data_d  = in_data;
        end
      end
      SHIFT: begin
        if (transfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d = 3'd0;
            if (accept) begin
              state_d = SHIFT;
              data_d  = in_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Statistics: clr_cnt wins over a same-cycle increment but leaves err_flag alone.
  always_comb begin
    err_flag_d   = err_flag_q;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;
    if (accept) begin
      err_flag_d   = mismatch;
      word_count_d = wrap_inc(word_count_q);
      if (mismatch) begin
        err_count_d = sat_inc(err_count_q);
      end
    end
    if (clr_cnt) begin
      err_count_d  = '0;
      word_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      data_q       <= 7'd0;
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

endmodule

// File: doc/parity_check_shifter.md
# parity_check_shifter

Downstream consumer of the majority-bit encoder. Accepts 8-bit encoded words (7 data bits plus the check bit at position 4) through a valid/ready handshake, recomputes and verifies the check bit, and keeps error and word statistics. It then streams the 7 recovered data bits out serially, with backpressure. Sits between the encoder output and the serial link / shifter stage.

## Interface
- CNT_W, 8, width of err_count and word_count
- MSB_FIRST, 1, 1 = serialize d6 first, 0 = d0 first
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_word/in_control valid
- in_ready  out  1  block can accept a word this cycle
- in_word  in  8  encoded word {d6,d5,d4,p,d3,d2,d1,d0}
- in_control  in  1  encoding mode the word was produced with
- clr_cnt  in  1  synchronous clear of err_count and word_count
- ser_valid  out  1  ser_data valid
- ser_ready  in  1  downstream takes ser_data this cycle
- ser_data  out  1  current serial data bit
- ser_first  out  1  marks the first bit of a frame, qualified by ser_valid
- err_flag  out  1  check-bit mismatch of the most recently accepted word
- err_count  out  CNT_W  saturating count of mismatched words
- word_count  out  CNT_W  wrapping count of accepted words

## Operation
- Accept event: in_valid && in_ready on a rising edge. The block latches data d = {in_word[7:5], in_word[3:0]}.
- Expected check bit:
  - Count zeros Z and ones O over in_word[6:5] and in_word[3:0] (d5..d0, 6 bits). in_word[7] (d6) is excluded.
  - in_control=0: exp = (Z > O).
  - in_control=1: exp = (O > Z).
  - Tie (3/3) gives exp = 0 in both modes.
- Mismatch = in_word[4] != exp.
  - err_flag is registered on accept and holds until the next accept.
  - err_count increments by 1 on each mismatch and saturates at 2^CNT_W-1.
- word_count increments on every accept and wraps to 0 after 2^CNT_W-1.
- clr_cnt zeroes both counters. It has priority over a same-cycle increment. err_flag is unaffected.
- FSM states:
  - IDLE: in_ready=1, ser_valid=0. An accept moves the FSM to SHIFT with bit index 0.
  - SHIFT: ser_valid=1; ser_data is the indexed bit (MSB_FIRST: d6,d5,...,d0; else d0..d6). Index advances only on ser_valid && ser_ready.
  - SHIFT exit, on the 7th transfer (index 6 && ser_ready):
    - If a new word is accepted in the same cycle, stay in SHIFT with index 0 and the new data.
    - Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==SHIFT && index==6 && ser_ready), so back-to-back frames have no bubble.
- ser_first = ser_valid && index==0.
- ser_data, ser_first and the data register hold stable while ser_valid && !ser_ready.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, index=0, data=0, ser_valid=0, ser_data=0, ser_first=0, err_flag=0, err_count=0, word_count=0. in_ready=1 once rst_n is deasserted.
- Reset asserted mid-frame aborts the frame immediately. No further bits are emitted and counters are cleared.
- Accept at edge N:
  - err_flag, err_count, word_count are updated after edge N.
  - First serial bit is valid in the cycle after edge N.
- Frame length: exactly 7 transfers. With ser_ready held high, a frame occupies 7 cycles and sustained throughput is 1 word per 7 cycles.
- in_ready is combinational from state, index and ser_ready. There is no combinational path from in_valid to any output.

## Test plan
- Reset values: assert rst_n=0 mid-frame -> all outputs at reset values within the same cycle, in_ready=1 after release, no partial frame resumes.
- Clean word, mode 0: in_word=8'h10, in_control=0 -> err_flag=0, word_count=1, serial 0,0,0,0,0,0,0 with ser_first on the first bit only.
- Tie, mode 1: in_word=8'h68, in_control=1 (d=7'b0111000, tie, exp=0) -> err_flag=0, serial 0,1,1,1,0,0,0 (MSB_FIRST=1).
- Error path: in_word=8'h00, in_control=0 (exp=1) -> err_flag=1, err_count=1. Then 8'h10/ctrl 0 -> err_flag=0, err_count stays 1. Then 255 more errors with CNT_W=8 -> err_count saturates at 255. word_count wraps to 0 after 256 accepts.
- Backpressure: drop ser_ready for 3 cycles at bit index 2 -> ser_data held, frame still exactly 7 transfers, in_ready=0 throughout.
- Back-to-back and clear: in_valid held high with two words and ser_ready=1 -> 14 consecutive valid bits, ser_first on cycles 1 and 8, word_count=2. clr_cnt asserted on an erroneous accept -> both counters read 0 next cycle, err_flag=1.
